// File: rtl/wb_arbiter_if.sv
// Bus bundle between the ALU/LSU write sources and the register-file write port.
// The arbiter takes the slave view; the source/sink side takes the master view.
interface wb_arbiter_if;
   logic        alu_valid;
   logic [4:0]  alu_addr;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_addr;
   logic [31:0] lsu_data;
   logic [4:0]  c_addr;
   logic        c_we;
   logic [31:0] c_in;
   logic [3:0]  fifo_count;

   modport master (
      output alu_valid, alu_addr, alu_data,
      output lsu_valid, lsu_addr, lsu_data,
      input  lsu_ready,
      input  c_addr, c_we, c_in, fifo_count
   );

   modport slave (
      input  alu_valid, alu_addr, alu_data,
      input  lsu_valid, lsu_addr, lsu_data,
      output lsu_ready,
      output c_addr, c_we, c_in, fifo_count
   );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: ALU has priority, LSU writes queue in a FIFO with WAW squash.
// Define WB_BYPASS_EN to let an LSU write issue directly when the FIFO is empty and the ALU is idle.
module wb_arbiter #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   wb_arbiter_if.slave  bus
);

   localparam int unsigned PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [3:0]  DEPTH_C = 4'(FIFO_DEPTH);

   typedef logic [PW-1:0] ptr_t;

   logic [4:0]            q_addr [FIFO_DEPTH];
   logic [31:0]           q_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] q_vld;
   ptr_t                  rd_ptr;
   logic [3:0]            count;

   logic [4:0]            nxt_addr [FIFO_DEPTH];
   logic [31:0]           nxt_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] nxt_vld;
   ptr_t                  rd_n;
   logic [3:0]            cnt_n;
   ptr_t                  slot;
   ptr_t                  dst;

   logic        alu_we;
   logic        lsu_ready;
   logic        lsu_acc;
   logic        lsu_keep;
   logic        deq;
   logic        bypass;
   logic        enq;
   logic        iss_we;
   logic [4:0]  iss_addr;
   logic [31:0] iss_data;

   logic        c_we_q;
   logic [4:0]  c_addr_q;
   logic [31:0] c_in_q;

   assign lsu_ready = !rst && (count < DEPTH_C);

   always_comb begin
      alu_we   = bus.alu_valid && (bus.alu_addr != '0);
      lsu_acc  = bus.lsu_valid && lsu_ready;
      lsu_keep = lsu_acc && (bus.lsu_addr != '0) &&
                 !(alu_we && (bus.lsu_addr == bus.alu_addr));
      deq      = !alu_we && q_vld[rd_ptr];
`ifdef WB_BYPASS_EN
      bypass   = !alu_we && (count == '0) && lsu_keep;
`else
      bypass   = 1'b0;
`endif
      enq      = lsu_keep && !bypass;
      rd_n     = rd_ptr + ptr_t'(deq);

      nxt_addr = q_addr;
      nxt_data = q_data;
      nxt_vld  = '0;
      cnt_n    = '0;
      slot     = '0;
      dst      = '0;
      // Rebuild the queue each cycle: squashed entries and the issued head drop
      // out, survivors are repacked contiguously from the new read pointer.
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
         slot = rd_ptr + ptr_t'(i);
         if (q_vld[slot] && !(alu_we && (q_addr[slot] == bus.alu_addr)) &&
             !(deq && (i == 0))) begin
            dst           = rd_n + ptr_t'(cnt_n);
            nxt_addr[dst] = q_addr[slot];
            nxt_data[dst] = q_data[slot];
            nxt_vld[dst]  = 1'b1;
            cnt_n         = cnt_n + 4'd1;
         end
      end
      if (enq) begin
         dst           = rd_n + ptr_t'(cnt_n);
         nxt_addr[dst] = bus.lsu_addr;
         nxt_data[dst] = bus.lsu_data;
         nxt_vld[dst]  = 1'b1;
         cnt_n         = cnt_n + 4'd1;
      end

      iss_we   = 1'b0;
      iss_addr = bus.alu_addr;
      iss_data = bus.alu_data;
      if (alu_we) begin
         iss_we = 1'b1;
      end else if (bypass) begin
         iss_we   = 1'b1;
         iss_addr = bus.lsu_addr;
         iss_data = bus.lsu_data;
      end else if (deq) begin
         iss_we   = 1'b1;
         iss_addr = q_addr[rd_ptr];
         iss_data = q_data[rd_ptr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_vld    <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         c_we_q   <= 1'b0;
         c_addr_q <= '0;
         c_in_q   <= '0;
      end else begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            q_addr[i] <= nxt_addr[i];
            q_data[i] <= nxt_data[i];
         end
         q_vld  <= nxt_vld;
         rd_ptr <= rd_n;
         count  <= cnt_n;
         c_we_q <= iss_we;
         if (iss_we) begin
            c_addr_q <= iss_addr;
            c_in_q   <= iss_data;
         end
      end
   end

   assign bus.lsu_ready  = lsu_ready;
   assign bus.c_we       = c_we_q;
   assign bus.c_addr     = c_addr_q;
   assign bus.c_in       = c_in_q;
   assign bus.fifo_count = count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (default build, WB_BYPASS_EN undefined, FIFO_DEPTH=4).
module tb_wb_arbiter;

   logic clk;
   logic rst;
   int   passes;
   int   total;
   logic [4:0] lsu_a;

   wb_arbiter_if bus ();

   wb_arbiter #(.FIFO_DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic set_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
      bus.alu_valid = v;
      bus.alu_addr  = a;
      bus.alu_data  = d;
   endtask

   task automatic set_lsu(input logic v, input logic [4:0] a, input logic [31:0] d);
      bus.lsu_valid = v;
      bus.lsu_addr  = a;
      bus.lsu_data  = d;
   endtask

   task automatic expect_wr(input string tag, input logic [4:0] a, input logic [31:0] d,
                            input logic [3:0] cnt);
      check({tag, "_we"},  32'(bus.c_we), 32'd1);
      check({tag, "_addr"}, 32'(bus.c_addr), 32'(a));
      check({tag, "_data"}, bus.c_in, d);
      check({tag, "_cnt"},  32'(bus.fifo_count), 32'(cnt));
   endtask

   initial begin
      passes = 0;
      total  = 0;
      rst    = 1'b1;
      set_alu(1'b0, 5'd0, 32'd0);
      set_lsu(1'b0, 5'd0, 32'd0);

      // Reset state
      tick();
      tick();
      check("rst_we",    32'(bus.c_we), 32'd0);
      check("rst_addr",  32'(bus.c_addr), 32'd0);
      check("rst_in",    bus.c_in, 32'd0);
      check("rst_cnt",   32'(bus.fifo_count), 32'd0);
      check("rst_ready", 32'(bus.lsu_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("rel_ready", 32'(bus.lsu_ready), 32'd1);

      // Single ALU write, then idle holds c_addr/c_in
      set_alu(1'b1, 5'd5, 32'h1234);
      tick();
      set_alu(1'b0, 5'd0, 32'd0);
      expect_wr("alu5", 5'd5, 32'h1234, 4'd0);
      tick();
      check("idle_we",   32'(bus.c_we), 32'd0);
      check("idle_addr", 32'(bus.c_addr), 32'd5);
      check("idle_in",   bus.c_in, 32'h1234);

      // LSU write goes through FIFO: issue two cycles after acceptance
      set_lsu(1'b1, 5'd7, 32'hA5A5A5A5);
      check("lsu7_ready", 32'(bus.lsu_ready), 32'd1);
      tick();
      set_lsu(1'b0, 5'd0, 32'd0);
      check("lsu7_n1_we",  32'(bus.c_we), 32'd0);
      check("lsu7_n1_cnt", 32'(bus.fifo_count), 32'd1);
      tick();
      expect_wr("lsu7_n2", 5'd7, 32'hA5A5A5A5, 4'd0);
      tick();
      check("lsu7_after_we", 32'(bus.c_we), 32'd0);

      // ALU busy six cycles while LSU offers 1..5: FIFO fills at 4
      lsu_a = 5'd1;
      for (int k = 1; k <= 6; k++) begin
         set_alu(1'b1, 5'(20 + k), 32'h200 + 32'(k));
         set_lsu(1'b1, lsu_a, 32'h100 + 32'(lsu_a));
         check("fill_ready", 32'(bus.lsu_ready), (k <= 4) ? 32'd1 : 32'd0);
         tick();
         expect_wr("fill_alu", 5'(20 + k), 32'h200 + 32'(k), (k < 4) ? 4'(k) : 4'd4);
         if (k <= 4 && lsu_a < 5'd5) lsu_a = lsu_a + 5'd1;
      end
      set_alu(1'b0, 5'd0, 32'd0);
      check("full_ready_same", 32'(bus.lsu_ready), 32'd0);
      tick();
      expect_wr("drain1", 5'd1, 32'h101, 4'd3);
      check("full_ready_next", 32'(bus.lsu_ready), 32'd1);
      tick();
      set_lsu(1'b0, 5'd0, 32'd0);
      expect_wr("drain2", 5'd2, 32'h102, 4'd3);
      for (int j = 3; j <= 5; j++) begin
         tick();
         expect_wr("drain", 5'(j), 32'h100 + 32'(j), 4'(5 - j));
      end
      tick();
      check("drain_end_we", 32'(bus.c_we), 32'd0);

      // WAW: buffered r9 squashed by later ALU r9
      set_lsu(1'b1, 5'd9, 32'h11);
      tick();
      set_lsu(1'b0, 5'd0, 32'd0);
      check("waw9_buf_we",  32'(bus.c_we), 32'd0);
      check("waw9_buf_cnt", 32'(bus.fifo_count), 32'd1);
      set_alu(1'b1, 5'd9, 32'h22);
      tick();
      set_alu(1'b0, 5'd0, 32'd0);
      expect_wr("waw9_alu", 5'd9, 32'h22, 4'd0);
      tick();
      check("waw9_nostale_we", 32'(bus.c_we), 32'd0);
      check("waw9_nostale_in", bus.c_in, 32'h22);

      // WAW on a same-cycle LSU write; older r13 entry survives
      set_lsu(1'b1, 5'd13, 32'h33);
      tick();
      check("waw12_pre_cnt", 32'(bus.fifo_count), 32'd1);
      set_alu(1'b1, 5'd12, 32'h44);
      set_lsu(1'b1, 5'd12, 32'h55);
      check("waw12_ready", 32'(bus.lsu_ready), 32'd1);
      tick();
      set_alu(1'b0, 5'd0, 32'd0);
      set_lsu(1'b0, 5'd0, 32'd0);
      expect_wr("waw12_alu", 5'd12, 32'h44, 4'd1);
      tick();
      expect_wr("waw12_r13", 5'd13, 32'h33, 4'd0);
      tick();
      check("waw12_end_we", 32'(bus.c_we), 32'd0);

      // Address 0 from both sources is discarded
      set_alu(1'b1, 5'd0, 32'hDEAD);
      set_lsu(1'b1, 5'd0, 32'hBEEF);
      check("zero_ready", 32'(bus.lsu_ready), 32'd1);
      tick();
      set_alu(1'b0, 5'd0, 32'd0);
      set_lsu(1'b0, 5'd0, 32'd0);
      check("zero_we",   32'(bus.c_we), 32'd0);
      check("zero_cnt",  32'(bus.fifo_count), 32'd0);
      check("zero_addr", 32'(bus.c_addr), 32'd13);
      tick();
      check("zero_next_we", 32'(bus.c_we), 32'd0);

      // Reset with three buffered entries and live inputs
      for (int k = 1; k <= 3; k++) begin
         set_alu(1'b1, 5'd30, 32'h400 + 32'(k));
         set_lsu(1'b1, 5'(k), 32'h300 + 32'(k));
         tick();
         check("prerst_cnt", 32'(bus.fifo_count), 32'(k));
      end
      rst = 1'b1;
      set_alu(1'b1, 5'd31, 32'h777);
      set_lsu(1'b1, 5'd4, 32'h304);
      #1;
      check("midrst_ready", 32'(bus.lsu_ready), 32'd0);
      tick();
      check("midrst_cnt",   32'(bus.fifo_count), 32'd0);
      check("midrst_we",    32'(bus.c_we), 32'd0);
      check("midrst_addr",  32'(bus.c_addr), 32'd0);
      check("midrst_in",    bus.c_in, 32'd0);
      check("midrst_ready2", 32'(bus.lsu_ready), 32'd0);
      rst = 1'b0;
      set_alu(1'b0, 5'd0, 32'd0);
      set_lsu(1'b0, 5'd0, 32'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("postrst_we",  32'(bus.c_we), 32'd0);
         check("postrst_cnt", 32'(bus.fifo_count), 32'd0);
      end
      check("postrst_ready", 32'(bus.lsu_ready), 32'd1);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
